// File: rtl/shift_unit_if.sv
// Request/response bus of the shift unit: valid/ready request carrying op, amount and
// load data, and a valid/ready response carrying the data register.
interface shift_unit_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [AMT_W-1:0] req_amt;
  logic [WIDTH-1:0] req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_amt, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_amt, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle WIDTH-bit shifter, one 1-bit step per clock, valid/ready request/response.
// Define SHIFT_UNIT_SOUT_EN to add the registered serial output 'sout'.
module shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
`ifdef SHIFT_UNIT_SOUT_EN
  output logic sout,
`endif
  shift_unit_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH) + 1;
  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_LSR   = 3'b010;
  localparam logic [2:0] OP_LSL   = 3'b011;
  localparam logic [2:0] OP_ASR   = 3'b100;
  localparam logic [2:0] OP_SIN   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_ROL   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] r, r_d;
  logic [AMT_W-1:0] cnt, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] n_eff;

  function automatic logic [WIDTH-1:0] step_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] v,
                                               input logic s);
    logic [WIDTH-1:0] res;
    case (op)
      OP_LSR:  res = {1'b0, v[WIDTH-1:1]};
      OP_LSL:  res = {v[WIDTH-2:0], 1'b0};
      OP_ASR:  res = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SIN:  res = {s, v[WIDTH-1:1]};
      OP_ROR:  res = {v[0], v[WIDTH-1:1]};
      OP_ROL:  res = {v[WIDTH-2:0], v[WIDTH-1]};
      default: res = v;
    endcase
    return res;
  endfunction

  // Amounts beyond the register width collapse to WIDTH steps.
  assign n_eff = (bus.req_amt > W_AMT) ? W_AMT : bus.req_amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      cnt   <= '0;
      op_q  <= OP_CLEAR;
    end else begin
      state <= state_d;
      r     <= r_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
    end
  end

  // The first step happens on the accepting edge, so BUSY only covers the remaining N-1.
  always_comb begin
    state_d = state;
    r_d     = r;
    cnt_d   = cnt;
    op_d    = op_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.req_op;
          if (bus.req_op == OP_CLEAR) begin
            r_d     = '0;
            state_d = DONE;
          end else if (bus.req_op == OP_LOAD) begin
            r_d     = bus.req_data;
            state_d = DONE;
          end else if (n_eff == '0) begin
            state_d = DONE;
          end else begin
            r_d = step_fn(bus.req_op, r, sin);
            if (n_eff == AMT_W'(1)) begin
              state_d = DONE;
            end else begin
              cnt_d   = n_eff - AMT_W'(1);
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        r_d   = step_fn(op_q, r, sin);
        cnt_d = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = r;

`ifdef SHIFT_UNIT_SOUT_EN
  logic       step_now;
  logic [2:0] step_op;

  always_comb begin
    step_now = 1'b0;
    step_op  = op_q;
    if (state == BUSY) begin
      step_now = 1'b1;
    end else if (state == IDLE && bus.req_valid &&
                 bus.req_op != OP_CLEAR && bus.req_op != OP_LOAD && n_eff != '0) begin
      step_now = 1'b1;
      step_op  = bus.req_op;
    end
  end

  // Capture the bit that falls off the register on each step; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sout <= 1'b0;
    end else if (step_now) begin
      sout <= (step_op == OP_LSL || step_op == OP_ROL) ? r[WIDTH-1] : r[0];
    end
  end
`endif
endmodule
